// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - shared core types: scoreboard sizing, exception and scoreboard entry
//
// Purpose: common sizing constants and structures for the issue/commit path.
//   NR_SB_ENTRIES  in-flight instruction slots (power of two)
//   TRANS_ID_BITS  width of a slot index / transaction id
//   NR_WB_PORTS    number of functional-unit writeback ports
//   exception      exception record carried with an instruction
//   scoreboard_entry  one in-flight instruction record
package ariane_pkg;

  localparam int unsigned NR_SB_ENTRIES = 4;
  localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);
  localparam int unsigned NR_WB_PORTS   = 3;

  typedef enum logic [2:0] {
    FU_NONE,
    FU_ALU,
    FU_BRANCH,
    FU_LOAD,
    FU_STORE,
    FU_MULT,
    FU_CSR
  } fu_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception;

  typedef struct packed {
    logic [63:0]              pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    fu_t                      fu;
    logic [7:0]               op;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic [63:0]              result;
    logic                     valid;
    logic                     use_imm;
    exception                 ex;
  } scoreboard_entry;

endpackage

// File: rtl/scoreboard.sv
// rtl/scoreboard.sv - in-order issue/commit scoreboard with multi-port writeback
//
// Purpose: circular buffer of in-flight instructions. Issue writes the slot at
// the issue pointer, functional units write results back by slot id, and the
// commit stage retires the oldest finished entry.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   flush_i                  drop every in-flight entry
//   full_o                   no free slot (registered count only)
//   decoded_instr_i/_valid_i instruction offered for issue
//   decoded_instr_ack_o      issue accepted this cycle
//   issue_trans_id_o         slot the next accepted instruction will occupy
//   wb_trans_id_i/_data_i/_ex_i/_valid_i  per-port writeback
//   commit_instr_o           entry at the commit pointer
//   commit_valid_o           head entry finished and committable
//   commit_ack_i             commit stage retires the head
//
// Build option: SB_WB_BYPASS_EN - when defined, a writeback hitting the head
// slot is forwarded combinationally to commit_instr_o/commit_valid_o in the
// same cycle; otherwise the head becomes committable one cycle later.
module scoreboard #(
  parameter int unsigned NR_ENTRIES  = ariane_pkg::NR_SB_ENTRIES,
  parameter int unsigned NR_WB_PORTS = ariane_pkg::NR_WB_PORTS
) (
  input  logic                                                clk_i,
  input  logic                                                rst_ni,
  input  logic                                                flush_i,
  output logic                                                full_o,
  input  ariane_pkg::scoreboard_entry                         decoded_instr_i,
  input  logic                                                decoded_instr_valid_i,
  output logic                                                decoded_instr_ack_o,
  output logic [ariane_pkg::TRANS_ID_BITS-1:0]                issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0][ariane_pkg::TRANS_ID_BITS-1:0] wb_trans_id_i,
  input  logic [NR_WB_PORTS-1:0][63:0]                        wb_data_i,
  input  ariane_pkg::exception [NR_WB_PORTS-1:0]              wb_ex_i,
  input  logic [NR_WB_PORTS-1:0]                              wb_valid_i,
  output ariane_pkg::scoreboard_entry                         commit_instr_o,
  output logic                                                commit_valid_o,
  input  logic                                                commit_ack_i
);

  import ariane_pkg::*;

  localparam int unsigned IDX_W = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;
  localparam int unsigned CNT_W = $clog2(NR_ENTRIES) + 1;

  scoreboard_entry        mem_q  [NR_ENTRIES];
  scoreboard_entry        mem_d  [NR_ENTRIES];
  scoreboard_entry        mem_wb [NR_ENTRIES];
  logic [NR_ENTRIES-1:0]  busy_q, busy_d;
  logic [IDX_W-1:0]       issue_ptr_q, issue_ptr_d;
  logic [IDX_W-1:0]       commit_ptr_q, commit_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   issue_fire;
  logic                   commit_fire;

  // Full is judged on the registered count, so a retire in the same cycle
  // never opens a slot for a same-cycle issue.
  assign full_o              = (count_q == CNT_W'(NR_ENTRIES));
  // rst_ni gates the ack so it is low for the whole reset, not just after an edge.
  assign decoded_instr_ack_o = rst_ni & decoded_instr_valid_i & ~full_o & ~flush_i;
  assign issue_trans_id_o    = TRANS_ID_BITS'(issue_ptr_q);

  // Entries as they look after this cycle's writebacks. Ports are scanned from
  // the highest index down so the lowest-index port hitting a slot wins.
  always_comb begin
    for (int i = 0; i < int'(NR_ENTRIES); i++) begin
      mem_wb[i] = mem_q[i];
      if (busy_q[i]) begin
        for (int k = int'(NR_WB_PORTS) - 1; k >= 0; k--) begin
          if (wb_valid_i[k] && (wb_trans_id_i[k] == TRANS_ID_BITS'(i))) begin
            mem_wb[i].result = wb_data_i[k];
            mem_wb[i].valid  = 1'b1;
            mem_wb[i].ex     = wb_ex_i[k].valid ? wb_ex_i[k] : mem_q[i].ex;
          end
        end
      end
    end
  end

`ifdef SB_WB_BYPASS_EN
  assign commit_instr_o = mem_wb[commit_ptr_q];
  assign commit_valid_o = (count_q != '0) & mem_wb[commit_ptr_q].valid;
`else
  assign commit_instr_o = mem_q[commit_ptr_q];
  assign commit_valid_o = (count_q != '0) & mem_q[commit_ptr_q].valid;
`endif

  assign issue_fire  = decoded_instr_ack_o;
  assign commit_fire = commit_ack_i & commit_valid_o;

  always_comb begin
    mem_d        = mem_wb;
    busy_d       = busy_q;
    issue_ptr_d  = issue_ptr_q;
    commit_ptr_d = commit_ptr_q;
    count_d      = count_q;

    if (flush_i) begin
      // Flush wins over everything: writebacks of this cycle are discarded too.
      for (int i = 0; i < int'(NR_ENTRIES); i++) begin
        mem_d[i]       = mem_q[i];
        mem_d[i].valid = 1'b0;
      end
      busy_d       = '0;
      issue_ptr_d  = '0;
      commit_ptr_d = '0;
      count_d      = '0;
    end else begin
      if (issue_fire) begin
        mem_d[issue_ptr_q]          = decoded_instr_i;
        mem_d[issue_ptr_q].trans_id = TRANS_ID_BITS'(issue_ptr_q);
        mem_d[issue_ptr_q].valid    = 1'b0;
        busy_d[issue_ptr_q]         = 1'b1;
        issue_ptr_d                 = issue_ptr_q + IDX_W'(1);
      end
      if (commit_fire) begin
        busy_d[commit_ptr_q]      = 1'b0;
        mem_d[commit_ptr_q].valid = 1'b0;
        commit_ptr_d              = commit_ptr_q + IDX_W'(1);
      end
      case ({issue_fire, commit_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NR_ENTRIES); i++) begin
        mem_q[i] <= '0;
      end
      busy_q       <= '0;
      issue_ptr_q  <= '0;
      commit_ptr_q <= '0;
      count_q      <= '0;
    end else begin
      for (int i = 0; i < int'(NR_ENTRIES); i++) begin
        mem_q[i] <= mem_d[i];
      end
      busy_q       <= busy_d;
      issue_ptr_q  <= issue_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_scoreboard.sv
// tb/tb_scoreboard.sv - directed vector bench for scoreboard
module tb_scoreboard;
  import ariane_pkg::*;

`ifdef SB_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic                  clk;
  logic                  rst_n;
  logic                  flush;
  logic                  full;
  scoreboard_entry       decoded_instr;
  logic                  decoded_valid;
  logic                  decoded_ack;
  logic [1:0]            issue_tid;
  logic [2:0][1:0]       wb_trans_id;
  logic [2:0][63:0]      wb_data;
  exception [2:0]        wb_ex;
  logic [2:0]            wb_valid;
  scoreboard_entry       commit_instr;
  logic                  commit_valid;
  logic                  commit_ack;

  int tests  = 0;
  int failed = 0;

  scoreboard dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .flush_i               (flush),
    .full_o                (full),
    .decoded_instr_i       (decoded_instr),
    .decoded_instr_valid_i (decoded_valid),
    .decoded_instr_ack_o   (decoded_ack),
    .issue_trans_id_o      (issue_tid),
    .wb_trans_id_i         (wb_trans_id),
    .wb_data_i             (wb_data),
    .wb_ex_i               (wb_ex),
    .wb_valid_i            (wb_valid),
    .commit_instr_o        (commit_instr),
    .commit_valid_o        (commit_valid),
    .commit_ack_i          (commit_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        iv;
    logic [63:0] pc;
    logic [2:0]  wbv;
    logic [5:0]  wid;   // {port2, port1, port0}
    logic [63:0] wd0;
    logic [63:0] wd1;
    logic [63:0] wd2;
    logic [2:0]  wexv;
    logic        cack;
    logic        e_ack;
    logic [1:0]  e_tid;
    logic        e_full;
    logic        e_cv;
    logic        chk_cpc;
    logic [63:0] e_cpc;
    logic [63:0] e_cres;
    logic        e_exv;
  } vec_t;

  function automatic vec_t mk(input logic f, input logic iv, input logic [63:0] pc,
                              input logic [2:0] wbv, input logic [5:0] wid,
                              input logic [63:0] wd0, input logic [63:0] wd1, input logic [63:0] wd2,
                              input logic [2:0] wexv, input logic cack,
                              input logic e_ack, input logic [1:0] e_tid, input logic e_full,
                              input logic e_cv, input logic chk_cpc, input logic [63:0] e_cpc,
                              input logic [63:0] e_cres, input logic e_exv);
    vec_t v;
    v.flush = f; v.iv = iv; v.pc = pc; v.wbv = wbv; v.wid = wid;
    v.wd0 = wd0; v.wd1 = wd1; v.wd2 = wd2; v.wexv = wexv; v.cack = cack;
    v.e_ack = e_ack; v.e_tid = e_tid; v.e_full = e_full; v.e_cv = e_cv;
    v.chk_cpc = chk_cpc; v.e_cpc = e_cpc; v.e_cres = e_cres; v.e_exv = e_exv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    scoreboard_entry e;
    e          = '0;
    e.pc       = v.pc;
    e.fu       = FU_ALU;
    e.rd       = 5'd7;
    e.valid    = 1'b1;   // must be forced to 0 by the scoreboard
    e.trans_id = 2'b11;  // must be replaced by the slot index
    decoded_instr = e;
    decoded_valid = v.iv;
    flush         = v.flush;
    commit_ack    = v.cack;
    wb_valid      = v.wbv;
    wb_data[0]    = v.wd0;
    wb_data[1]    = v.wd1;
    wb_data[2]    = v.wd2;
    for (int k = 0; k < 3; k++) begin
      wb_trans_id[k]    = v.wid[2*k +: 2];
      wb_ex[k]          = '0;
      wb_ex[k].valid    = v.wexv[k];
      wb_ex[k].cause    = 64'd5;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    #1;
    chk({tag, " ack"},  decoded_ack,  v.e_ack);
    chk({tag, " tid"},  issue_tid,    v.e_tid);
    chk({tag, " full"}, full,         v.e_full);
    chk({tag, " cv"},   commit_valid, v.e_cv);
    if (v.chk_cpc) chk({tag, " cpc"}, commit_instr.pc, v.e_cpc);
    if (v.e_cv) begin
      chk({tag, " cres"}, commit_instr.result, v.e_cres);
      chk({tag, " exv"},  commit_instr.ex.valid, v.e_exv);
    end
  endtask

  localparam logic [5:0] W000 = 6'b00_00_00;
  vec_t vec [23];
  vec_t idle_v;

  initial begin
    // fl iv pc      wbv     wid                     wd0     wd1      wd2     wexv   ck  ack tid full cv  cc cpc      cres    exv
    vec[0]  = mk(0, 1, 'h100, 3'b000, W000,                  0,      0,       0,      3'b000, 0,  1, 0, 0, 0,   1, 'h000, 0,      0);
    vec[1]  = mk(0, 1, 'h104, 3'b000, W000,                  0,      0,       0,      3'b000, 0,  1, 1, 0, 0,   1, 'h100, 0,      0);
    vec[2]  = mk(0, 1, 'h108, 3'b000, W000,                  0,      0,       0,      3'b000, 0,  1, 2, 0, 0,   1, 'h100, 0,      0);
    vec[3]  = mk(0, 1, 'h10C, 3'b000, W000,                  0,      0,       0,      3'b000, 0,  1, 3, 0, 0,   1, 'h100, 0,      0);
    vec[4]  = mk(0, 1, 'h110, 3'b000, W000,                  0,      0,       0,      3'b000, 0,  0, 0, 1, 0,   1, 'h100, 0,      0);
    vec[5]  = mk(0, 0, 'h0,   3'b010, {2'd0, 2'd1, 2'd0},    0,      'h11,    0,      3'b000, 0,  0, 0, 1, 0,   1, 'h100, 0,      0);
    vec[6]  = mk(0, 0, 'h0,   3'b000, W000,                  0,      0,       0,      3'b000, 0,  0, 0, 1, 0,   1, 'h100, 0,      0);
    vec[7]  = mk(0, 0, 'h0,   3'b001, W000,                  'h10,   0,       0,      3'b000, 0,  0, 0, 1, BYP, 1, 'h100, 'h10,   0);
    vec[8]  = mk(0, 1, 'h120, 3'b000, W000,                  0,      0,       0,      3'b000, 1,  0, 0, 1, 1,   1, 'h100, 'h10,   0);
    vec[9]  = mk(0, 1, 'h120, 3'b000, W000,                  0,      0,       0,      3'b000, 1,  1, 0, 0, 1,   1, 'h104, 'h11,   0);
    vec[10] = mk(0, 0, 'h0,   3'b000, W000,                  0,      0,       0,      3'b000, 1,  0, 1, 0, 0,   1, 'h108, 0,      0);
    vec[11] = mk(0, 0, 'h0,   3'b111, {2'd2, 2'd3, 2'd2},    'hA,    'h33,    'hB,    3'b110, 0,  0, 1, 0, BYP, 1, 'h108, 'hA,    0);
    vec[12] = mk(0, 0, 'h0,   3'b000, W000,                  0,      0,       0,      3'b000, 0,  0, 1, 0, 1,   1, 'h108, 'hA,    0);
    vec[13] = mk(0, 0, 'h0,   3'b000, W000,                  0,      0,       0,      3'b000, 1,  0, 1, 0, 1,   1, 'h108, 'hA,    0);
    vec[14] = mk(0, 0, 'h0,   3'b000, W000,                  0,      0,       0,      3'b000, 0,  0, 1, 0, 1,   1, 'h10C, 'h33,   1);
    vec[15] = mk(0, 0, 'h0,   3'b001, {2'd0, 2'd0, 2'd1},    'hDEAD, 0,       0,      3'b000, 1,  0, 1, 0, 1,   1, 'h10C, 'h33,   1);
    vec[16] = mk(0, 1, 'h124, 3'b100, W000,                  0,      0,       'h55,   3'b000, 0,  1, 1, 0, BYP, 1, 'h120, 'h55,   0);
    vec[17] = mk(1, 1, 'h128, 3'b001, {2'd0, 2'd0, 2'd1},    'h66,   0,       0,      3'b000, 1,  0, 2, 0, 1,   1, 'h120, 'h55,   0);
    vec[18] = mk(0, 1, 'h130, 3'b000, W000,                  0,      0,       0,      3'b000, 0,  1, 0, 0, 0,   0, 'h0,   0,      0);
    vec[19] = mk(0, 0, 'h0,   3'b010, W000,                  0,      'h77,    0,      3'b000, 0,  0, 1, 0, BYP, 1, 'h130, 'h77,   0);
    vec[20] = mk(0, 0, 'h0,   3'b000, W000,                  0,      0,       0,      3'b000, 0,  0, 1, 0, 1,   1, 'h130, 'h77,   0);
    vec[21] = mk(0, 0, 'h0,   3'b000, W000,                  0,      0,       0,      3'b000, 1,  0, 1, 0, 1,   1, 'h130, 'h77,   0);
    vec[22] = mk(0, 0, 'h0,   3'b000, W000,                  0,      0,       0,      3'b000, 0,  0, 1, 0, 0,   0, 'h0,   0,      0);
    idle_v  = mk(0, 0, 'h0,   3'b000, W000,                  0,      0,       0,      3'b000, 0,  0, 0, 0, 0,   0, 'h0,   0,      0);

    // Reset state, with an issue request held high during reset.
    rst_n = 1'b0;
    drive(idle_v);
    decoded_valid = 1'b1;
    #2;
    chk("rst ack",  decoded_ack,  1'b0);
    chk("rst full", full,         1'b0);
    chk("rst cv",   commit_valid, 1'b0);
    chk("rst tid",  issue_tid,    2'd0);
    tests++;
    if (commit_instr !== '0) begin
      failed++;
      $display("FAIL rst commit_instr: got %h expected 0", commit_instr);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(idle_v);

    for (int i = 0; i < 23; i++) run_vec(vec[i], $sformatf("v%0d", i));

    // Mid-operation reset: state is count 0, both pointers at 1.
    run_vec(mk(0, 1, 'h200, 3'b000, W000, 0, 0, 0, 3'b000, 0, 1, 1, 0, 0, 0, 'h0, 0, 0), "h0");
    run_vec(mk(0, 1, 'h204, 3'b001, {2'd0, 2'd0, 2'd1}, 'h99, 0, 0, 3'b000, 0, 1, 2, 0, BYP, 1, 'h200, 'h99, 0), "h1");
    run_vec(mk(0, 0, 'h0, 3'b000, W000, 0, 0, 0, 3'b000, 0, 0, 3, 0, 1, 1, 'h200, 'h99, 0), "h2");
    @(negedge clk);
    drive(idle_v);
    decoded_valid = 1'b1;
    commit_ack    = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst ack",  decoded_ack,  1'b0);
    chk("arst cv",   commit_valid, 1'b0);
    chk("arst full", full,         1'b0);
    chk("arst tid",  issue_tid,    2'd0);
    tests++;
    if (commit_instr !== '0) begin
      failed++;
      $display("FAIL arst commit_instr: got %h expected 0", commit_instr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(idle_v);
    run_vec(mk(0, 1, 'h300, 3'b000, W000, 0, 0, 0, 3'b000, 1, 1, 0, 0, 0, 1, 'h0, 0, 0), "post0");
    run_vec(mk(0, 0, 'h0, 3'b000, W000, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 1, 'h300, 0, 0), "post1");
    run_vec(mk(0, 0, 'h0, 3'b100, {2'd0, 2'd0, 2'd0}, 0, 0, 'h3C, 3'b100, 0, 0, 1, 0, BYP, 1, 'h300, 'h3C, 1), "post2");
    run_vec(mk(0, 0, 'h0, 3'b000, W000, 0, 0, 0, 3'b000, 1, 0, 1, 0, 1, 1, 'h300, 'h3C, 1), "post3");
    run_vec(mk(0, 0, 'h0, 3'b000, W000, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0, 'h0, 0, 0), "post4");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
